alu_serial8: RTL
================

ALU_SERIAL8 -- requirements
Module: alu_serial8

Interface
REQ-001 Parameter: WIDTH, 8, operand and result width in bits (legal 2..16).
REQ-002 Port: clk  input  1  rising-edge clock.
REQ-003 Port: rst_n  input  1  asynchronous, active-low reset.
REQ-004 Port: in_valid  input  1  operand set presented.
REQ-005 Port: in_ready  output  1  block can accept operands.
REQ-006 Port: a  input  WIDTH  first operand.
REQ-007 Port: b  input  WIDTH  second operand.
REQ-008 Port: sub  input  1  0 = a+b, 1 = a-b.
REQ-009 Port: out_valid  output  1  result available.
REQ-010 Port: out_ready  input  1  consumer takes result.
REQ-011 Port: q  output  WIDTH  result.
REQ-012 Port: c  output  1  carry out (for subtract, 1 = no borrow).
REQ-013 Port: v  output  1  signed overflow.
REQ-014 Port: z  output  1  result equals zero.

Function
REQ-015 The FSM SHALL have exactly three states: IDLE, SHIFT and DONE.
REQ-016 in_ready SHALL equal 1 only in IDLE, and out_valid SHALL equal 1 only in DONE.
REQ-017 In IDLE, an in_valid=1 rising edge SHALL capture a, capture b inverted when sub=1 (unchanged otherwise), load carry=sub, clear the bit counter and enter SHIFT.
REQ-018 SHIFT SHALL process one bit per clock, LSB first, through a 1-bit full adder, shifting the sum bit into the result register from the MSB end.
REQ-019 After the WIDTH-th SHIFT edge the FSM SHALL enter DONE, so out_valid rises exactly WIDTH clocks after the accepting edge.
REQ-020 In DONE, q, c, v and z SHALL be held stable until the edge where out_ready=1, and the FSM SHALL then return to IDLE.
REQ-021 in_ready SHALL rise on the clock after the output handshake; no input is accepted in the same cycle as an output handshake.
REQ-022 in_valid asserted in SHIFT or DONE SHALL be ignored, and operand inputs SHALL NOT be sampled outside the IDLE accept edge.
REQ-023 c SHALL be the final full-adder carry.
REQ-024 Arithmetic SHALL be modulo 2^WIDTH (q wraps around).
REQ-025 out_ready asserted while not in DONE SHALL have no effect.

Reset
REQ-026 rst_n=0 SHALL immediately force IDLE, in_ready=1, out_valid=0, q=0, c=0, v=0 and z=0, independent of clk.
REQ-027 Reset asserted in SHIFT or DONE SHALL discard the operation in progress, with no output handshake occurring for it.
REQ-028 The first accept after reset deassertion SHALL be possible on the first rising edge with rst_n=1.

Configuration
REQ-029 With ALU_SERIAL_FLAGS_EN defined, v SHALL equal (carry into MSB) XOR (carry out of MSB), and z SHALL equal (q==0), both valid in DONE.
REQ-030 Without ALU_SERIAL_FLAGS_EN, v and z SHALL be constant 0 and the flag logic SHALL be absent; q and c are unaffected.

Structure
REQ-031 Package alu_pkg SHALL hold the FSM state typedef (IDLE/SHIFT/DONE) and the default WIDTH constant.
REQ-032 The 1-bit full adder SHALL be sub-module alu_fa1 (inputs a, b, ci; outputs s, co), instantiated once.
REQ-033 The bit counter SHALL be clog2(WIDTH)+1 bits wide and SHALL NOT wrap during an operation.

Verification
REQ-034 Scenario: add 100+27 with sub=0 -> out_valid 8 clocks after accept; q=127, c=0, v=0, z=0.
REQ-035 Scenario: add 100+28 with sub=0 -> q=128, c=0, v=1 (flags enabled); add 200+100 -> q=44, c=1, v=0.
REQ-036 Scenario: sub 5-5 -> q=0, c=1, z=1; sub 3-5 -> q=8'hFE, c=0, v=0, z=0.
REQ-037 Scenario: out_ready held 0 for 5 clocks in DONE -> q and flags unchanged, in_ready=0 throughout; in_ready=1 on the clock after out_ready=1.
REQ-038 Scenario: in_valid=1 with new operands during SHIFT -> ignored, first result unaffected; rst_n pulsed low at SHIFT bit 4 -> all outputs 0 asynchronously, IDLE, no out_valid pulse.
REQ-039 Scenario: build without ALU_SERIAL_FLAGS_EN and run 5-5 -> q=0, c=1, z=0, v=0.

Source files
------------

// File: rtl/alu_pkg.sv
// ============================================================================
// Module   : alu_pkg
// Purpose  : Shared FSM state type and default width for the serial ALU.
// Revision : 1.0
// ============================================================================
`default_nettype none

package alu_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

endpackage

`default_nettype wire

// File: rtl/alu_fa1.sv
// ============================================================================
// Module   : alu_fa1
// Purpose  : 1-bit full adder used as the bit-serial arithmetic core.
// Revision : 1.0
// ============================================================================
`default_nettype none

module alu_fa1 (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));

endmodule

`default_nettype wire

// File: rtl/alu_serial8.sv
// ============================================================================
// Module   : alu_serial8
// Purpose  : Bit-serial add/subtract, one bit per clock, valid/ready framed.
//            Define ALU_SERIAL_FLAGS_EN to build the v/z flag logic.
// Revision : 1.0
// ============================================================================
`default_nettype none

module alu_serial8
    import alu_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] q,
    output logic             c,
    output logic             v,
    output logic             z
);

    localparam int               CNT_W    = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             carry_q, carry_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             fa_s, fa_co;
    logic             accept;

    assign accept = (state_q == IDLE) && in_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid)          state_d = SHIFT;
            SHIFT:   if (cnt_q == LAST_BIT) state_d = DONE;
            DONE:    if (out_ready)         state_d = IDLE;
            default:                        state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);
    end

    alu_fa1 u_fa1 (
        .a  (a_q[0]),
        .b  (b_q[0]),
        .ci (carry_q),
        .s  (fa_s),
        .co (fa_co)
    );

    // Subtraction is a + ~b + 1: invert b on capture and seed the carry with 1.
    always_comb begin
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        if (accept) begin
            a_d     = a;
            b_d     = sub ? ~b : b;
            carry_d = sub;
            cnt_d   = '0;
        end else if (state_q == SHIFT) begin
            a_d     = a_q >> 1;
            b_d     = b_q >> 1;
            res_d   = {fa_s, res_q[WIDTH-1:1]};
            carry_d = fa_co;
            cnt_d   = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
        end
    end

    assign q = res_q;
    assign c = carry_q;

`ifdef ALU_SERIAL_FLAGS_EN
    logic last_bit;
    logic v_q, z_q;

    assign last_bit = (state_q == SHIFT) && (cnt_q == LAST_BIT);

    // On the MSB step carry_q is the carry into the MSB and fa_co the carry out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_q <= 1'b0;
            z_q <= 1'b0;
        end else if (last_bit) begin
            v_q <= carry_q ^ fa_co;
            z_q <= (res_d == '0);
        end
    end

    assign v = v_q;
    assign z = z_q;
`else
    assign v = 1'b0;
    assign z = 1'b0;
`endif

endmodule

`default_nettype wire
